// File: rtl/dice_round_ctrl.sv
// Round sequencer for the two-player dice game: takes alternating throws,
// scores each round, times the result window and drives the display inputs.
module dice_round_ctrl #(
    parameter int ROUNDS   = 5,
    parameter int SHOW_CYC = 1500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       req1,
    input  logic       req2,
    input  logic [2:0] dice,
    output logic [2:0] die1,
    output logic [2:0] die2,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [3:0] round,
    output logic       turn,
    output logic       times,
    output logic       is_final,
    output logic       is_finish
);

    localparam int             CW         = $clog2(SHOW_CYC + 1);
    localparam logic [CW-1:0]  CNT_LAST   = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [3:0]     ROUND_LAST = 4'(ROUNDS);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT1  = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_SHOW   = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    die1_q, die1_d, die2_q, die2_d;
    logic [3:0]    score1_q, score1_d, score2_q, score2_d;
    logic [3:0]    round_q, round_d;
    logic          turn_q, turn_d, times_q, times_d;
    logic          final_q, final_d, finish_q, finish_d;

    logic dice_ok_s, start_s, take1_s, take2_s, show_end_s;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        if (v == 4'd15) begin
            return v;
        end else begin
            return v + 4'd1;
        end
    endfunction

    assign dice_ok_s  = (dice != 3'd0) && (dice != 3'd7);
    assign start_s    = start && ((state_q == ST_IDLE) || (state_q == ST_FINISH));
    assign take1_s    = (state_q == ST_WAIT1) && req1 && dice_ok_s;
    assign take2_s    = (state_q == ST_WAIT2) && req2 && dice_ok_s;
    assign show_end_s = (state_q == ST_SHOW) && (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (start_s) state_d = ST_WAIT1;
                else         state_d = state_q;
            end
            ST_WAIT1: begin
                if (take1_s) state_d = ST_WAIT2;
                else         state_d = ST_WAIT1;
            end
            ST_WAIT2: begin
                if (take2_s) state_d = ST_SHOW;
                else         state_d = ST_WAIT2;
            end
            ST_SHOW: begin
                if (!show_end_s)                  state_d = ST_SHOW;
                else if (round_q == ROUND_LAST)   state_d = ST_FINISH;
                else                              state_d = ST_WAIT1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values, derived from the upcoming state
    always_comb begin
        die1_d   = die1_q;
        die2_d   = die2_q;
        score1_d = score1_q;
        score2_d = score2_q;
        round_d  = round_q;
        if (start_s) begin
            die1_d   = 3'd0;
            die2_d   = 3'd0;
            score1_d = 4'd0;
            score2_d = 4'd0;
            round_d  = 4'd1;
        end else if (take1_s) begin
            die1_d = dice;
        end else if (take2_s) begin
            die2_d = dice;
            if (die1_q > dice)      score1_d = sat_inc(score1_q);
            else if (dice > die1_q) score2_d = sat_inc(score2_q);
            else                    score1_d = score1_q;
        end else if (show_end_s && (round_q != ROUND_LAST)) begin
            round_d = round_q + 4'd1;
        end else begin
            round_d = round_q;
        end

        // Window counter runs only inside SHOW, so it is zero on every entry
        if ((state_q == ST_SHOW) && !show_end_s) cnt_d = cnt_q + CNT_ONE;
        else                                     cnt_d = '0;

        turn_d   = (state_d == ST_WAIT2);
        times_d  = (state_d == ST_SHOW);
        finish_d = (state_d == ST_FINISH);
        final_d  = ((state_d == ST_WAIT1) || (state_d == ST_WAIT2) || (state_d == ST_SHOW))
                   && (round_d == ROUND_LAST);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            die1_q   <= 3'd0;
            die2_q   <= 3'd0;
            score1_q <= 4'd0;
            score2_q <= 4'd0;
            round_q  <= 4'd0;
            turn_q   <= 1'b0;
            times_q  <= 1'b0;
            final_q  <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            die1_q   <= die1_d;
            die2_q   <= die2_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            round_q  <= round_d;
            turn_q   <= turn_d;
            times_q  <= times_d;
            final_q  <= final_d;
            finish_q <= finish_d;
        end
    end

    assign die1      = die1_q;
    assign die2      = die2_q;
    assign score1    = score1_q;
    assign score2    = score2_q;
    assign round     = round_q;
    assign turn      = turn_q;
    assign times     = times_q;
    assign is_final  = final_q;
    assign is_finish = finish_q;

endmodule
